// File: rtl/psum_gbf_accum_pkg.sv
// Shared definitions for the psum global-buffer accumulator: FSM encoding,
// default geometry and the lane-count derivation.
package psum_gbf_accum_pkg;

    localparam int DATA_BITWIDTH_DEF     = 16;
    localparam int GBF_DATA_BITWIDTH_DEF = 512;
    localparam int ADDR_BITWIDTH_DEF     = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int calc_lanes(input int line_bits, input int lane_bits);
        return line_bits / lane_bits;
    endfunction

endpackage

// File: rtl/psum_bram_sdp.sv
// Simple dual-port line store: one write port, one read port with a
// registered (1-cycle) read. A read colliding with a write returns old data.
module psum_bram_sdp #(
    parameter int DW = 512,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; array contents stay undefined.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/psum_gbf_accum.sv
// Accumulates upstream psum lines into a line buffer (read-modify-write with
// bypass) and drains address ranges out over a valid/ready stream.
module psum_gbf_accum
    import psum_gbf_accum_pkg::*;
#(
    parameter int DATA_BITWIDTH     = DATA_BITWIDTH_DEF,
    parameter int GBF_DATA_BITWIDTH = GBF_DATA_BITWIDTH_DEF,
    parameter int ADDR_BITWIDTH     = ADDR_BITWIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         psum_write_en,
    input  logic [ADDR_BITWIDTH-1:0]     psum_BRAM_addr,
    input  logic [GBF_DATA_BITWIDTH-1:0] out_data,
    input  logic                         first_acc,
    input  logic                         su_add_finish,
    input  logic                         drain_req,
    input  logic [ADDR_BITWIDTH-1:0]     drain_base,
    input  logic [ADDR_BITWIDTH:0]       drain_len,
    output logic                         drain_valid,
    input  logic                         drain_ready,
    output logic [GBF_DATA_BITWIDTH-1:0] drain_data,
    output logic                         acc_done,
    output logic                         drain_done,
    output logic                         busy,
    output logic                         wr_drop_err,
    output state_t                       fsm_state
);

    localparam int LANES = calc_lanes(GBF_DATA_BITWIDTH, DATA_BITWIDTH);
    localparam int DW    = DATA_BITWIDTH;
    localparam int GW    = GBF_DATA_BITWIDTH;
    localparam int AW    = ADDR_BITWIDTH;

    state_t        state;
    logic          accept, drain_start, drain_adv;
    logic [AW-1:0] drain_addr;
    logic [AW:0]   drain_left;
    logic          fin1;

    logic          s1_valid, s1_first, s2_valid, s3_valid;
    logic [AW-1:0] s1_addr, s2_addr, s3_addr;
    logic [GW-1:0] s1_data, s2_data, s3_data;
    logic [GW-1:0] rd_data, old_line, sum_line;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    assign accept      = psum_write_en && (state != ST_DRAIN);
    assign drain_start = (state == ST_IDLE) && !psum_write_en && !su_add_finish &&
                         drain_req && (drain_len != '0);
    // Next beat is fetched only on a transfer, so rd_data holds still while stalled.
    assign drain_adv   = (state == ST_DRAIN) && drain_valid && drain_ready && (drain_left != '0);
    assign rd_en       = accept || drain_start || drain_adv;
    assign rd_addr     = accept ? psum_BRAM_addr :
                         ((state == ST_IDLE) ? drain_base : drain_addr);

    assign drain_data  = rd_data;
    assign busy        = (state != ST_IDLE);
    assign fsm_state   = state;

    // S2 is the newest pending write, S3 the one the memory read just missed.
    always_comb begin
        old_line = rd_data;
        if (s3_valid && (s3_addr == s1_addr)) old_line = s3_data;
        if (s2_valid && (s2_addr == s1_addr)) old_line = s2_data;
        sum_line = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_line[i*DW +: DW] = old_line[i*DW +: DW] + s1_data[i*DW +: DW];
        end
        if (s1_first) sum_line = s1_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            s3_valid <= 1'b0;
            s3_addr  <= '0;
            s3_data  <= '0;
            fin1     <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_first <= first_acc;
            s1_addr  <= psum_BRAM_addr;
            s1_data  <= out_data;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_data  <= sum_line;
            s3_valid <= s2_valid;
            s3_addr  <= s2_addr;
            s3_data  <= s2_data;
            fin1     <= su_add_finish && (state != ST_DRAIN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            acc_done    <= 1'b0;
            drain_valid <= 1'b0;
            drain_done  <= 1'b0;
            wr_drop_err <= 1'b0;
            drain_addr  <= '0;
            drain_left  <= '0;
        end else begin
            acc_done   <= fin1;
            drain_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (psum_write_en) begin
                        state <= su_add_finish ? ST_FLUSH : ST_ACCUM;
                    end else if (su_add_finish) begin
                        state <= ST_FLUSH;
                    end else if (drain_req) begin
                        if (drain_len == '0) begin
                            drain_done <= 1'b1;
                        end else begin
                            state       <= ST_DRAIN;
                            drain_valid <= 1'b1;
                            drain_addr  <= drain_base + 1'b1;
                            drain_left  <= drain_len - 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (su_add_finish) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (!fin1 && !s1_valid && !psum_write_en) state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (psum_write_en) wr_drop_err <= 1'b1;
                    if (drain_valid && drain_ready) begin
                        if (drain_left == '0) begin
                            drain_valid <= 1'b0;
                            drain_done  <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            drain_addr <= drain_addr + 1'b1;
                            drain_left <= drain_left - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    psum_bram_sdp #(
        .DW(GW),
        .AW(AW)
    ) u_bram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (s2_valid),
        .wr_addr(s2_addr),
        .wr_data(s2_data),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_psum_gbf_accum.sv
// Bench for psum_gbf_accum: table vectors, directed corner sequences and a
// randomized stream checked against a sequential read-modify-write model.
module tb_psum_gbf_accum;
    import psum_gbf_accum_pkg::*;

    localparam int DW    = 16;
    localparam int GW    = 512;
    localparam int AW    = 10;
    localparam int LANES = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          psum_write_en = 1'b0;
    logic [AW-1:0] psum_BRAM_addr = '0;
    logic [GW-1:0] out_data = '0;
    logic          first_acc = 1'b0;
    logic          su_add_finish = 1'b0;
    logic          drain_req = 1'b0;
    logic [AW-1:0] drain_base = '0;
    logic [AW:0]   drain_len = '0;
    logic          drain_valid;
    logic          drain_ready = 1'b0;
    logic [GW-1:0] drain_data;
    logic          acc_done, drain_done, busy, wr_drop_err;
    state_t        fsm_state;

    int checks = 0;
    int failures = 0;
    logic [GW-1:0] model_mem [DEPTH];
    logic [GW-1:0] exp_q [$];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
        logic [DW-1:0] sum;
    } vec_t;
    vec_t vecs [7];

    psum_gbf_accum dut (
        .clk(clk), .reset(reset), .psum_write_en(psum_write_en),
        .psum_BRAM_addr(psum_BRAM_addr), .out_data(out_data), .first_acc(first_acc),
        .su_add_finish(su_add_finish), .drain_req(drain_req), .drain_base(drain_base),
        .drain_len(drain_len), .drain_valid(drain_valid), .drain_ready(drain_ready),
        .drain_data(drain_data), .acc_done(acc_done), .drain_done(drain_done),
        .busy(busy), .wr_drop_err(wr_drop_err), .fsm_state(fsm_state)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] lane_add(input logic [GW-1:0] a, input logic [GW-1:0] b);
        logic [GW-1:0] r;
        int s;
        for (int i = 0; i < LANES; i++) begin
            s = int'(a[i*DW +: DW]) + int'(b[i*DW +: DW]);
            r[i*DW +: DW] = DW'(s % 65536);
        end
        return r;
    endfunction

    function automatic logic [GW-1:0] rand_line();
        logic [GW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic drive_write(input int addr, input logic [GW-1:0] data, input bit first, input bit fin);
        psum_write_en  = 1'b1;
        psum_BRAM_addr = AW'(addr);
        out_data       = data;
        first_acc      = first;
        su_add_finish  = fin;
        if (first) model_mem[addr] = data;
        else       model_mem[addr] = lane_add(model_mem[addr], data);
        step();
        psum_write_en = 1'b0;
        first_acc     = 1'b0;
        su_add_finish = 1'b0;
    endtask

    // Called in the cycle after su_add_finish was sampled.
    task automatic check_acc_done(input string name);
        check({name, "_acc_t1"}, GW'(acc_done), GW'(0));
        check({name, "_busy_t1"}, GW'(busy), GW'(1));
        step();
        check({name, "_acc_t2"}, GW'(acc_done), GW'(1));
        step();
        check({name, "_acc_t3"}, GW'(acc_done), GW'(0));
        check({name, "_busy_t3"}, GW'(busy), GW'(0));
    endtask

    // mode 0: ready always, 1: ready toggles, 2: random ready. exp_q holds expected beats.
    task automatic do_drain(input int base, input int len, input int mode, input bit inject);
        logic [GW-1:0] held, exp_line;
        bit have_held;
        int beats, dones, last_x, done_at;
        have_held = 0; beats = 0; dones = 0; last_x = -1; done_at = -100;
        held = '0;
        drain_base  = AW'(base);
        drain_len   = (AW+1)'(len);
        drain_req   = 1'b1;
        drain_ready = 1'b0;
        step();
        drain_req = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (drain_done) begin
                dones++;
                done_at = cyc;
            end
            if (beats == len && dones > 0) break;
            psum_write_en = inject && (cyc == 1);
            first_acc     = inject && (cyc == 1);
            if (inject && cyc == 1) begin
                psum_BRAM_addr = AW'((base + len - 1) % DEPTH);
                out_data       = rand_line();
            end
            case (mode)
                0:       drain_ready = 1'b1;
                1:       drain_ready = (cyc % 2) == 1;
                default: drain_ready = 1'($urandom_range(0, 1));
            endcase
            if (drain_valid) begin
                if (have_held) check("drain_stable", drain_data, held);
                if (drain_ready) begin
                    if (exp_q.size() > 0) begin
                        exp_line = exp_q.pop_front();
                        check("drain_data", drain_data, exp_line);
                    end
                    beats++;
                    last_x    = cyc;
                    have_held = 0;
                end else begin
                    held      = drain_data;
                    have_held = 1;
                end
            end
            step();
        end
        psum_write_en = 1'b0;
        first_acc     = 1'b0;
        drain_ready   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (drain_done) dones++;
        end
        check("drain_beats", GW'(beats), GW'(len));
        check("drain_done_count", GW'(dones), GW'(1));
        check("drain_done_timing", GW'(done_at), GW'(last_x + 1));
        check("drain_valid_after", GW'(drain_valid), GW'(0));
        check("drain_busy_after", GW'(busy), GW'(0));
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{10'd5,    16'h0003, 16'h0004, 16'h0007};
        vecs[1] = '{10'd20,   16'hFFFF, 16'h0002, 16'h0001};
        vecs[2] = '{10'd21,   16'h8000, 16'h8000, 16'h0000};
        vecs[3] = '{10'd22,   16'h0000, 16'h0000, 16'h0000};
        vecs[4] = '{10'd1023, 16'h1234, 16'h1111, 16'h2345};
        vecs[5] = '{10'd0,    16'hFFFE, 16'h0001, 16'hFFFF};
        vecs[6] = '{10'd512,  16'h7FFF, 16'h0001, 16'h8000};

        reset = 1'b1;
        step();
        step();
        check("rst_drain_valid", GW'(drain_valid), GW'(0));
        check("rst_acc_done", GW'(acc_done), GW'(0));
        check("rst_drain_done", GW'(drain_done), GW'(0));
        check("rst_busy", GW'(busy), GW'(0));
        check("rst_wr_drop_err", GW'(wr_drop_err), GW'(0));
        check("rst_drain_data", drain_data, GW'(0));
        reset = 1'b0;
        step();

        // Table: overwrite then accumulate on the very next cycle, drain one line.
        for (int r = 0; r < 7; r++) begin
            drive_write(int'(vecs[r].addr), {LANES{vecs[r].v1}}, 1'b1, 1'b0);
            drive_write(int'(vecs[r].addr), {LANES{vecs[r].v2}}, 1'b0, 1'b1);
            check_acc_done("vec");
            exp_q.push_back({LANES{vecs[r].sum}});
            do_drain(int'(vecs[r].addr), 1, r % 3, 1'b0);
        end

        // Three back-to-back writes to one line.
        drive_write(9, {LANES{16'd1}}, 1'b1, 1'b0);
        drive_write(9, {LANES{16'd2}}, 1'b0, 1'b0);
        drive_write(9, {LANES{16'd3}}, 1'b0, 1'b1);
        check_acc_done("b2b");
        exp_q.push_back({LANES{16'd6}});
        do_drain(9, 1, 0, 1'b0);

        // Alternating 9/10 exercises the two-behind bypass.
        drive_write(10, rand_line(), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_write((i % 2 == 1) ? 10 : 9, rand_line(), 1'b0, i == 5);
        end
        check_acc_done("alt");
        exp_q.push_back(model_mem[9]);
        exp_q.push_back(model_mem[10]);
        do_drain(9, 2, 2, 1'b0);

        // Pass with no writes.
        su_add_finish = 1'b1;
        step();
        su_add_finish = 1'b0;
        check_acc_done("empty");

        // Zero-length drain.
        do_drain(3, 0, 0, 1'b0);

        // Wrapping drain with toggling ready.
        drive_write(1022, rand_line(), 1'b1, 1'b0);
        drive_write(1023, rand_line(), 1'b1, 1'b0);
        drive_write(0, rand_line(), 1'b1, 1'b0);
        drive_write(1, rand_line(), 1'b1, 1'b1);
        check_acc_done("wrap");
        for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[(1022 + i) % DEPTH]);
        do_drain(1022, 4, 1, 1'b0);

        // Write during drain is dropped; drained data shows memory untouched.
        for (int a = 100; a < 104; a++) drive_write(a, rand_line(), 1'b1, a == 103);
        check_acc_done("drop");
        check("drop_err_before", GW'(wr_drop_err), GW'(0));
        for (int a = 100; a < 104; a++) exp_q.push_back(model_mem[a]);
        do_drain(100, 4, 1, 1'b1);
        check("drop_err_set", GW'(wr_drop_err), GW'(1));
        step();
        check("drop_err_sticky", GW'(wr_drop_err), GW'(1));

        // Reset in the middle of a stalled drain.
        drain_base = AW'(100);
        drain_len  = (AW+1)'(8);
        drain_req  = 1'b1;
        step();
        drain_req   = 1'b0;
        drain_ready = 1'b0;
        step();
        check("mid_drain_valid", GW'(drain_valid), GW'(1));
        #2;
        reset = 1'b1;
        #1;
        check("rstd_drain_valid", GW'(drain_valid), GW'(0));
        check("rstd_state", GW'(fsm_state), GW'(ST_IDLE));
        check("rstd_busy", GW'(busy), GW'(0));
        step();
        reset = 1'b0;
        step();
        check("rstd_wr_drop_err", GW'(wr_drop_err), GW'(0));
        check("rstd_drain_done", GW'(drain_done), GW'(0));

        // Random stream over a small window to provoke every hazard distance.
        for (int a = 40; a < 48; a++) drive_write(a, rand_line(), 1'b1, 1'b0);
        for (int n = 0; n < 300; n++) begin
            if (n == 299 || $urandom_range(0, 9) < 7) begin
                drive_write($urandom_range(40, 47), rand_line(), $urandom_range(0, 4) == 0, n == 299);
            end else begin
                step();
            end
        end
        check_acc_done("rand");
        for (int a = 40; a < 48; a++) exp_q.push_back(model_mem[a]);
        do_drain(40, 8, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
